// File: rtl/branch_pkg.sv
// Shared definitions for the SAP-II program-counter / branch stage:
// branch opcode encodings, FSM state constants, default sizing and the
// flag-condition helper used to decide whether a branch is taken.
package branch_pkg;

    localparam int          DEF_ADDR_W      = 16;
    localparam logic [15:0] DEF_RESET_PC    = 16'h0000;
    localparam int          DEF_STACK_DEPTH = 4;

    typedef logic [2:0] br_op_t;

    localparam br_op_t BR_NOP = 3'd0;
    localparam br_op_t BR_JMP = 3'd1;
    localparam br_op_t BR_JZ  = 3'd2;
    localparam br_op_t BR_JNZ = 3'd3;
    localparam br_op_t BR_JM  = 3'd4;
    localparam br_op_t BR_JP  = 3'd5;
    localparam br_op_t BR_CALL = 3'd6;
    localparam br_op_t BR_RET = 3'd7;

    localparam logic ST_RUN   = 1'b0;
    localparam logic ST_FLUSH = 1'b1;

    // Flag condition for an opcode; stack availability is judged separately.
    function automatic logic br_cond(input br_op_t op, input logic s, input logic z);
        logic c;
        case (op)
            BR_JMP, BR_CALL, BR_RET: c = 1'b1;
            BR_JZ:                   c = z;
            BR_JNZ:                  c = ~z;
            BR_JM:                   c = s;
            BR_JP:                   c = ~s;
            default:                 c = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/branch_pc_ret_stack.sv
// Return-address LIFO for nested CALL/RET. Only compiled in when
// BRANCH_STACK_EN is defined; the single-link build has no use for it.
// Push is dropped when full and pop is dropped when empty; the caller is
// expected to gate these and report the fault itself.
`ifdef BRANCH_STACK_EN
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W-1:0] top_ptr;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign wr_ptr  = IDX_W'(count);
    assign top_ptr = IDX_W'(count - CNT_W'(1));
    assign top     = empty ? '0 : mem[top_ptr];

    // Entry storage; contents above count are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr] <= push_data;
    end

    // Occupancy count; push and pop are never requested together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (push && !full)
            count <= count + CNT_W'(1);
        else if (pop && !empty)
            count <= count - CNT_W'(1);
    end

endmodule
`endif

// File: rtl/branch_pc.sv
// Program counter and conditional-branch stage for the SAP-II datapath.
// Evaluates JMP/JZ/JNZ/JM/JP/CALL/RET against the registered S/Z flags,
// drives the PC toward the memory address register and inserts a
// one-cycle bubble after every taken branch so fetch can drop the stale
// word.
//
// Build option BRANCH_STACK_EN: replaces the single link register with a
// STACK_DEPTH-entry return stack and adds the sticky stk_err output.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | normal fetch; branch requests accepted, PC advances on pc_inc
// ST_FLUSH | bubble after a taken branch; requests refused, PC held
module branch_pc
    import branch_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
`ifdef BRANCH_STACK_EN
    ,
    parameter int                STACK_DEPTH = DEF_STACK_DEPTH
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_inc,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [2:0]        br_op,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              s_f,
    input  logic              z_f,
    output logic [ADDR_W-1:0] pc,
    output logic              br_taken
`ifdef BRANCH_STACK_EN
    ,
    output logic              stk_err
`endif
);

    logic              state;
    logic              accept;
    logic              cond;
    logic              taken;
    logic              is_call;
    logic              is_ret;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] ret_addr;
    logic [ADDR_W-1:0] pc_next;

    assign br_ready = (state == ST_RUN);
    assign accept   = br_valid && br_ready;
    assign cond     = br_cond(br_op, s_f, z_f);
    assign is_call  = (br_op == BR_CALL);
    assign is_ret   = (br_op == BR_RET);
    assign pc_plus1 = pc + ADDR_W'(1);

`ifdef BRANCH_STACK_EN
    logic              stk_full;
    logic              stk_empty;
    logic              stk_ok;
    logic              stk_fault;
    logic              do_push;
    logic              do_pop;
    logic [ADDR_W-1:0] stk_top;

    // A CALL into a full stack or a RET from an empty one is demoted to
    // not-taken so the PC keeps running and no bubble is inserted.
    always_comb begin
        stk_ok = 1'b1;
        if (is_call && stk_full)
            stk_ok = 1'b0;
        if (is_ret && stk_empty)
            stk_ok = 1'b0;
    end

    assign taken     = accept && cond && stk_ok;
    assign stk_fault = accept && cond && !stk_ok;
    assign do_push   = taken && is_call;
    assign do_pop    = taken && is_ret;
    assign ret_addr  = stk_top;

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_ret_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (do_push),
        .pop       (do_pop),
        .push_data (pc_plus1),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // Stack fault flag holds until reset so software can find it later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stk_err <= 1'b0;
        else if (stk_fault)
            stk_err <= 1'b1;
    end
`else
    logic [ADDR_W-1:0] link;

    assign taken    = accept && cond;
    assign ret_addr = link;

    // Single return address; each CALL overwrites the previous one.
    // Resets to zero regardless of RESET_PC so an unpaired RET is defined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            link <= '0;
        else if (taken && is_call)
            link <= pc_plus1;
    end
`endif

    // Next PC: hold in the bubble, jump when taken, else advance on pc_inc.
    always_comb begin
        pc_next = pc;
        if (state == ST_RUN) begin
            if (taken)
                pc_next = is_ret ? ret_addr : br_target;
            else
                pc_next = pc + ADDR_W'(pc_inc);
        end
    end

    // PC, bubble FSM and taken pulse. FLUSH always falls back to RUN since
    // nothing is accepted while in it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            state    <= ST_RUN;
            br_taken <= 1'b0;
        end else begin
            pc       <= pc_next;
            state    <= taken ? ST_FLUSH : ST_RUN;
            br_taken <= taken;
        end
    end

endmodule

// File: tb/tb_branch_pc.sv
// Self-checking bench for branch_pc: directed scenarios from the test
// plan plus a randomized run, all compared against a behavioural model
// that tracks PC, bubble, link/return stack and the stack fault flag.
module tb_branch_pc;
    import branch_pkg::*;

    localparam int DEPTH = DEF_STACK_DEPTH;

    logic        clk;
    logic        rst_n;
    logic        pc_inc;
    logic        br_valid;
    logic        br_ready;
    logic [2:0]  br_op;
    logic [15:0] br_target;
    logic        s_f;
    logic        z_f;
    logic [15:0] pc;
    logic        br_taken;
`ifdef BRANCH_STACK_EN
    logic        stk_err;
`endif

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int unsigned m_pc;
    int unsigned m_link;
    int unsigned m_stk[$];
    bit          m_flush;
    bit          m_taken;
    bit          m_err;

    branch_pc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc_inc    (pc_inc),
        .br_valid  (br_valid),
        .br_ready  (br_ready),
        .br_op     (br_op),
        .br_target (br_target),
        .s_f       (s_f),
        .z_f       (z_f),
        .pc        (pc),
        .br_taken  (br_taken)
`ifdef BRANCH_STACK_EN
        ,
        .stk_err   (stk_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input bit v, input logic [2:0] op, input logic [15:0] t,
                         input bit s, input bit z, input bit inc);
        br_valid  = v;
        br_op     = op;
        br_target = t;
        s_f       = s;
        z_f       = z;
        pc_inc    = inc;
    endtask

    task automatic model_reset();
        m_pc    = 0;
        m_link  = 0;
        m_stk.delete();
        m_flush = 0;
        m_taken = 0;
        m_err   = 0;
    endtask

    // Advance the model with the inputs present at the edge, then clock.
    task automatic tick();
        bit take;
        if (m_flush) begin
            m_flush = 0;
            m_taken = 0;
        end else begin
            take = 0;
            if (br_valid) begin
                case (br_op)
                    BR_JMP, BR_CALL, BR_RET: take = 1;
                    BR_JZ:  take = z_f;
                    BR_JNZ: take = !z_f;
                    BR_JM:  take = s_f;
                    BR_JP:  take = !s_f;
                    default: take = 0;
                endcase
            end
`ifdef BRANCH_STACK_EN
            if (take && br_op == BR_CALL && m_stk.size() == DEPTH) begin take = 0; m_err = 1; end
            if (take && br_op == BR_RET && m_stk.size() == 0) begin take = 0; m_err = 1; end
`endif
            if (take) begin
                if (br_op == BR_RET) begin
`ifdef BRANCH_STACK_EN
                    m_pc = m_stk.pop_back();
`else
                    m_pc = m_link;
`endif
                end else begin
                    if (br_op == BR_CALL) begin
`ifdef BRANCH_STACK_EN
                        m_stk.push_back((m_pc + 1) % 65536);
`else
                        m_link = (m_pc + 1) % 65536;
`endif
                    end
                    m_pc = br_target;
                end
                m_flush = 1;
                m_taken = 1;
            end else begin
                m_pc    = (m_pc + pc_inc) % 65536;
                m_taken = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 16'h0000); end
        checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL reset_taken got %b want 0", br_taken); end
        checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", br_ready); end
`ifdef BRANCH_STACK_EN
        checks++; if (stk_err !== 1'b0) begin errors++; $display("FAIL reset_stk_err got %b want 0", stk_err); end
`endif
    endtask

    task automatic test_inc();
        logic [15:0] exp;
        drive(0, BR_NOP, 16'h0, 0, 0, 1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp = 16'(i);
            checks++; if (pc !== exp) begin errors++; $display("FAIL inc_pc got %h want %h", pc, exp); end
            checks++; if (br_taken !== 1'b0 || br_ready !== 1'b1)
                begin errors++; $display("FAIL inc_ctl got taken=%b ready=%b want 0/1", br_taken, br_ready); end
        end
    endtask

    task automatic test_jz();
        drive(1, BR_JZ, 16'h1234, 0, 1, 1);
        tick();
        drive(0, BR_NOP, 16'h0, 0, 0, 1);
        checks++; if (pc !== 16'h1234) begin errors++; $display("FAIL jz_taken_pc got %h want 1234", pc); end
        checks++; if (br_taken !== 1'b1 || br_ready !== 1'b0)
            begin errors++; $display("FAIL jz_bubble got taken=%b ready=%b want 1/0", br_taken, br_ready); end
        tick();
        checks++; if (pc !== 16'h1234) begin errors++; $display("FAIL jz_flush_hold got %h want 1234", pc); end
        checks++; if (br_taken !== 1'b0 || br_ready !== 1'b1)
            begin errors++; $display("FAIL jz_after_flush got taken=%b ready=%b want 0/1", br_taken, br_ready); end
        tick();
        checks++; if (pc !== 16'h1235) begin errors++; $display("FAIL jz_resume got %h want 1235", pc); end
        drive(1, BR_JZ, 16'h1234, 0, 0, 1);
        tick();
        checks++; if (pc !== 16'h1236 || br_taken !== 1'b0 || br_ready !== 1'b1)
            begin errors++; $display("FAIL jz_not_taken got pc=%h taken=%b ready=%b want 1236/0/1", pc, br_taken, br_ready); end
    endtask

    task automatic test_sign();
        // flags from 0x80: s=1 z=0
        drive(1, BR_JM, 16'h0040, 1, 0, 1);
        tick();
        checks++; if (pc !== 16'h0040 || br_taken !== 1'b1) begin errors++; $display("FAIL jm_neg got pc=%h taken=%b want 0040/1", pc, br_taken); end
        drive(1, BR_JP, 16'h0050, 1, 0, 1);
        tick();
        tick();
        checks++; if (pc !== 16'h0041 || br_taken !== 1'b0) begin errors++; $display("FAIL jp_neg got pc=%h taken=%b want 0041/0", pc, br_taken); end
        // flags from 0x4D: s=0 z=0
        drive(1, BR_JP, 16'h0050, 0, 0, 1);
        tick();
        checks++; if (pc !== 16'h0050 || br_taken !== 1'b1) begin errors++; $display("FAIL jp_pos got pc=%h taken=%b want 0050/1", pc, br_taken); end
        drive(1, BR_JM, 16'h0040, 0, 0, 1);
        tick();
        tick();
        checks++; if (pc !== 16'h0051 || br_taken !== 1'b0) begin errors++; $display("FAIL jm_pos got pc=%h taken=%b want 0051/0", pc, br_taken); end
    endtask

    task automatic test_call_ret();
        drive(1, BR_JMP, 16'h0010, 0, 0, 0);
        tick();
        drive(0, BR_NOP, 16'h0, 0, 0, 0);
        tick();
        drive(1, BR_CALL, 16'h0200, 0, 0, 1);
        tick();
        checks++; if (pc !== 16'h0200 || br_taken !== 1'b1) begin errors++; $display("FAIL call_pc got pc=%h taken=%b want 0200/1", pc, br_taken); end
        drive(0, BR_NOP, 16'h0, 0, 0, 1);
        tick();
        tick();
        checks++; if (pc !== 16'h0201) begin errors++; $display("FAIL call_body got %h want 0201", pc); end
        drive(1, BR_RET, 16'hDEAD, 0, 0, 1);
        tick();
        checks++; if (pc !== 16'h0011 || br_taken !== 1'b1) begin errors++; $display("FAIL ret_pc got pc=%h taken=%b want 0011/1", pc, br_taken); end
        drive(0, BR_NOP, 16'h0, 0, 0, 0);
        tick();
`ifdef BRANCH_STACK_EN
        for (int i = 0; i < 4; i++) begin
            drive(1, BR_CALL, 16'(16'h1000 + i * 16'h0100), 0, 0, 0);
            tick();
            drive(0, BR_NOP, 16'h0, 0, 0, 0);
            tick();
        end
        checks++; if (pc !== 16'h1300 || stk_err !== 1'b0) begin errors++; $display("FAIL nest4 got pc=%h err=%b want 1300/0", pc, stk_err); end
        drive(1, BR_CALL, 16'h2000, 0, 0, 1);
        tick();
        checks++; if (pc !== 16'h1301 || br_taken !== 1'b0 || br_ready !== 1'b1 || stk_err !== 1'b1)
            begin errors++; $display("FAIL call_full got pc=%h taken=%b ready=%b err=%b want 1301/0/1/1", pc, br_taken, br_ready, stk_err); end
        for (int i = 0; i < 4; i++) begin
            drive(1, BR_RET, 16'h0, 0, 0, 0);
            tick();
            checks++; if (pc !== m_pc[15:0] || br_taken !== 1'b1) begin errors++; $display("FAIL ret_lifo got pc=%h taken=%b want %h/1", pc, br_taken, m_pc[15:0]); end
            drive(0, BR_NOP, 16'h0, 0, 0, 0);
            tick();
        end
        checks++; if (pc !== 16'h0012) begin errors++; $display("FAIL ret_outer got %h want 0012", pc); end
        drive(1, BR_RET, 16'h0, 0, 0, 1);
        tick();
        checks++; if (pc !== 16'h0013 || br_taken !== 1'b0 || stk_err !== 1'b1)
            begin errors++; $display("FAIL ret_empty got pc=%h taken=%b err=%b want 0013/0/1", pc, br_taken, stk_err); end
`else
        drive(1, BR_CALL, 16'h0400, 0, 0, 0);
        tick();
        drive(0, BR_NOP, 16'h0, 0, 0, 0);
        tick();
        drive(1, BR_CALL, 16'h0500, 0, 0, 0);
        tick();
        drive(0, BR_NOP, 16'h0, 0, 0, 0);
        tick();
        drive(1, BR_RET, 16'h0, 0, 0, 0);
        tick();
        checks++; if (pc !== 16'h0401 || br_taken !== 1'b1) begin errors++; $display("FAIL link_overwrite got pc=%h taken=%b want 0401/1", pc, br_taken); end
        drive(0, BR_NOP, 16'h0, 0, 0, 0);
        tick();
`endif
    endtask

    task automatic test_wrap();
        drive(1, BR_JMP, 16'hFFFF, 0, 0, 0);
        tick();
        drive(0, BR_NOP, 16'h0, 0, 0, 1);
        tick();
        checks++; if (pc !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre got %h want ffff", pc); end
        tick();
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL wrap got %h want 0000", pc); end
    endtask

    task automatic test_back_to_back();
        drive(1, BR_JMP, 16'h0100, 0, 0, 1);
        tick();
        drive(1, BR_JMP, 16'h0300, 0, 0, 1);
        checks++; if (br_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready got %b want 0", br_ready); end
        tick();
        checks++; if (pc !== 16'h0100 || br_taken !== 1'b0) begin errors++; $display("FAIL b2b_ignored got pc=%h taken=%b want 0100/0", pc, br_taken); end
        tick();
        checks++; if (pc !== 16'h0300 || br_taken !== 1'b1) begin errors++; $display("FAIL b2b_accept got pc=%h taken=%b want 0300/1", pc, br_taken); end
        drive(0, BR_NOP, 16'h0, 0, 0, 0);
        tick();
    endtask

    task automatic test_async_reset();
        drive(1, BR_JMP, 16'h0ABC, 0, 0, 1);
        tick();
        drive(0, BR_NOP, 16'h0, 0, 0, 1);
        checks++; if (br_ready !== 1'b0) begin errors++; $display("FAIL arst_pre_ready got %b want 0", br_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (pc !== 16'h0000 || br_taken !== 1'b0 || br_ready !== 1'b1)
            begin errors++; $display("FAIL arst got pc=%h taken=%b ready=%b want 0000/0/1", pc, br_taken, br_ready); end
`ifdef BRANCH_STACK_EN
        checks++; if (stk_err !== 1'b0) begin errors++; $display("FAIL arst_stk_err got %b want 0", stk_err); end
`endif
        #3;
        rst_n = 1'b1;
        model_reset();
        drive(0, BR_NOP, 16'h0, 0, 0, 0);
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
            checks++; if (br_ready !== !m_flush) begin errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", i, br_ready, !m_flush); end
            tick();
            checks++; if (pc !== m_pc[15:0]) begin errors++; $display("FAIL rnd_pc cyc %0d got %h want %h", i, pc, m_pc[15:0]); end
            checks++; if (br_taken !== m_taken) begin errors++; $display("FAIL rnd_taken cyc %0d got %b want %b", i, br_taken, m_taken); end
`ifdef BRANCH_STACK_EN
            checks++; if (stk_err !== m_err) begin errors++; $display("FAIL rnd_stk_err cyc %0d got %b want %b", i, stk_err, m_err); end
`endif
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, BR_NOP, 16'h0, 0, 0, 0);
        model_reset();
        #12;
        rst_n = 1'b1;
        tick();
        test_reset();
        test_inc();
        test_jz();
        test_sign();
        test_call_ret();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_pc.md
Name: branch_pc

Overview:
- Program-counter and conditional-branch stage directly downstream of the S/Z flag register in the SAP-II datapath.
- Consumes the registered sign/zero flags and decides JMP/JZ/JNZ/JM/JP/CALL/RET; otherwise advances the PC.
- Drives the memory address register.
- Inserts a one-cycle bubble after any taken branch so the fetch stage discards the stale word.

Parameters:
- ADDR_W, 16, PC/target width.
- RESET_PC, 16'h0000, PC value on reset.
- STACK_DEPTH, 4, return-stack entries (used only with BRANCH_STACK_EN).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- pc_inc  in  1  advance PC by 1 this cycle
- br_valid  in  1  branch request present
- br_ready  out  1  stage can accept a request; combinational, =1 in RUN, 0 in FLUSH
- br_op  in  3  0 NOP, 1 JMP, 2 JZ, 3 JNZ, 4 JM, 5 JP, 6 CALL, 7 RET
- br_target  in  ADDR_W  destination address
- s_f  in  1  sign flag from flag register
- z_f  in  1  zero flag from flag register
- pc  out  ADDR_W  current program counter (registered)
- br_taken  out  1  registered, one-cycle pulse after a taken branch
- stk_err  out  1  sticky stack over/underflow (present only with BRANCH_STACK_EN)

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, link=0, br_taken=0, state=RUN (so br_ready=1), stk_err=0. Takes effect immediately, including mid-FLUSH.
- Accept: br_valid && br_ready at a rising edge. br_valid in FLUSH is ignored and not queued; the requester holds it.
- Condition evaluated on s_f/z_f in the accept cycle:
  - JMP, CALL, RET: always taken.
  - JZ: z_f=1. JNZ: z_f=0.
  - JM: s_f=1. JP: s_f=0.
  - NOP: never taken.
- Taken:
  - pc <= br_target; RET uses pc <= link.
  - CALL also sets link <= pc+1 (mod 2^ADDR_W).
  - pc_inc ignored that cycle.
  - Next cycle: state=FLUSH, br_taken=1.
- Not taken, or no accept: pc <= pc + pc_inc. Wraps FFFF -> 0000, no flag.
- FLUSH lasts exactly one cycle:
  - br_ready=0, pc holds, pc_inc ignored.
  - Returns to RUN; br_taken falls to 0.
- Back-to-back taken branches: minimum 2 cycles apart.
- RET with no prior CALL: jumps to link (RESET_PC-independent 0 after reset).
- States: RUN -(taken accept)-> FLUSH -(always)-> RUN.

Optional Feature:
- Macro: BRANCH_STACK_EN.
- Defined: link is replaced by a STACK_DEPTH-entry LIFO.
  - CALL pushes pc+1; RET pops.
  - CALL when full, or RET when empty: treated as not taken (pc <= pc + pc_inc, no FLUSH, no br_taken). stk_err=1, sticky until reset.
  - Nested CALLs return in LIFO order.
- Undefined: single link register, overwritten by each CALL; stk_err port absent.

Decomposition:
- Shared package branch_pkg: br_op encodings (BR_NOP..BR_RET), state enum (ST_RUN, ST_FLUSH), default ADDR_W/RESET_PC constants.
- One natural sub-module: ret_stack (push/pop/full/empty LIFO), instantiated only under BRANCH_STACK_EN.

Test Plan:
1. Release reset, pc_inc=1 for 3 cycles -> pc 0000, 0001, 0002, 0003; br_taken=0; br_ready=1 throughout.
2. JZ target 0x1234:
   - z_f=1 -> pc=1234 next edge; br_taken=1 and br_ready=0 for one cycle; pc stays 1234 despite pc_inc=1; then 1235.
   - z_f=0 -> pc+1, no bubble.
3. Flag from In=0x80 (s_f=1, z_f=0):
   - JM 0x0040 -> pc=0040; JP 0x0050 -> not taken.
   - Repeat with In=0x4D: JP taken, JM not.
4. pc=0x0010, CALL 0x0200 -> pc=0200; later RET -> pc=0011, br_taken pulses each time.
   - With BRANCH_STACK_EN: 5 nested CALLs -> 5th not taken, stk_err=1.
   - RET on empty stack -> not taken, stk_err stays 1.
5. pc=FFFF, pc_inc=1 -> pc=0000.
   - br_valid held during FLUSH -> accepted only the following cycle.
6. Assert rst_n=0 mid-cycle during FLUSH -> pc=0000, br_taken=0, br_ready=1 immediately, without waiting for clk.
